// File: rtl/link_fifo_buffer_pkg.sv
// Shared interconnect definitions: the packet type and the null packet
// shown on an idle link.
`ifndef LINK_FIFO_BUFFER_PKG_SV
`define LINK_FIFO_BUFFER_PKG_SV

package link_fifo_buffer_pkg;

    typedef struct packed {
        logic [3:0]  dst;
        logic [11:0] payload;
    } packet_t;

endpackage

`define NULL_PACKET (link_fifo_buffer_pkg::packet_t'(16'h0000))

`endif

// File: rtl/link_if.sv
// Point-to-point req/ack link carrying one packet per completed handshake.
interface link_if;
    import link_fifo_buffer_pkg::*;

    logic    req;
    logic    ack;
    packet_t packet;

    modport sender   (output req, output packet, input ack);
    modport receiver (input req, input packet, output ack);
endinterface

// File: rtl/link_fifo_buffer.sv
// Circular packet FIFO between two req/ack links. There is no input-to-output
// bypass, so every packet spends at least one cycle in storage.
module link_fifo_buffer
    import link_fifo_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    link_if.receiver                 input_link,
    link_if.sender                   output_link,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    packet_t         mem_q [DEPTH];
    packet_t         mem_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic            push_s;
    logic            pop_s;
    logic            not_full_s;
    logic            not_empty_s;

    // Link-facing flags depend only on registered occupancy.
    assign not_full_s  = (occ_q != FULL_COUNT);
    assign not_empty_s = (occ_q != {CW{1'b0}});

    assign input_link.ack     = not_full_s;
    assign output_link.req    = not_empty_s;
    assign output_link.packet = not_empty_s ? mem_q[head_q] : `NULL_PACKET;
    assign occupancy          = occ_q;

    assign push_s = input_link.req & not_full_s;
    assign pop_s  = output_link.ack & not_empty_s;

    // Next-state for pointers, counter and storage.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        mem_d  = mem_q;
        if (push_s) begin
            mem_d[tail_q] = input_link.packet;
            tail_d        = tail_q + PW'(1);
        end else begin
            tail_d = tail_q;
        end
        if (pop_s) begin
            head_d = head_q + PW'(1);
        end else begin
            head_d = head_q;
        end
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= {PW{1'b0}};
            tail_q <= {PW{1'b0}};
            occ_q  <= {CW{1'b0}};
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Storage is never reset; it is masked by occupancy when empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_link_fifo_buffer.sv
// Directed self-checking bench for link_fifo_buffer at DEPTH=4.
module tb_link_fifo_buffer;
    import link_fifo_buffer_pkg::*;

    logic       clk;
    logic       reset;
    logic [2:0] occ;
    int         errors;
    int         checks;

    link_if in_l ();
    link_if out_l ();

    link_fifo_buffer #(.DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .input_link  (in_l),
        .output_link (out_l),
        .occupancy   (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic packet_t pk(input int n);
        return packet_t'(16'h5000 | 16'(n));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_l.req = 1'b0; in_l.packet = pk(0); out_l.ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (out_l.req !== 1'b0) begin errors++; $display("FAIL reset_req got %b expected 0", out_l.req); end
        checks++; if (out_l.packet !== `NULL_PACKET) begin errors++; $display("FAIL reset_pkt got %h expected %h", out_l.packet, `NULL_PACKET); end
        checks++; if (in_l.ack !== 1'b1) begin errors++; $display("FAIL reset_ack got %b expected 1", in_l.ack); end
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d expected 0", occ); end
    endtask

    task automatic test_fill_drain();
        out_l.ack = 1'b0; in_l.req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_l.packet = pk(i);
            tick();
            checks++; if (occ !== 3'(i + 1)) begin errors++; $display("FAIL fill_occ got %0d expected %0d", occ, i + 1); end
            checks++; if (in_l.ack !== (i < 3)) begin errors++; $display("FAIL fill_ack got %b expected %b", in_l.ack, (i < 3)); end
        end
        in_l.req = 1'b0; out_l.ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_l.packet !== pk(i) || out_l.req !== 1'b1) begin errors++; $display("FAIL drain_pkt got %h expected %h", out_l.packet, pk(i)); end
            tick();
        end
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL drain_occ got %0d expected 0", occ); end
        checks++; if (out_l.req !== 1'b0 || out_l.packet !== `NULL_PACKET) begin errors++; $display("FAIL drain_idle got req=%b pkt=%h expected req=0 pkt=%h", out_l.req, out_l.packet, `NULL_PACKET); end
    endtask

    task automatic test_streaming();
        out_l.ack = 1'b1; in_l.req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_l.packet = pk(16 + i);
            tick();
            checks++; if (out_l.packet !== pk(16 + i)) begin errors++; $display("FAIL stream_pkt got %h expected %h", out_l.packet, pk(16 + i)); end
            checks++; if (occ !== 3'd1) begin errors++; $display("FAIL stream_occ got %0d expected 1", occ); end
        end
        in_l.req = 1'b0;
        tick();
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL stream_end_occ got %0d expected 0", occ); end
    endtask

    task automatic test_full_pop();
        out_l.ack = 1'b0; in_l.req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_l.packet = pk(32 + i);
            tick();
        end
        in_l.packet = pk(36); out_l.ack = 1'b1;
        checks++; if (in_l.ack !== 1'b0 || occ !== 3'd4) begin errors++; $display("FAIL full_state got ack=%b occ=%0d expected ack=0 occ=4", in_l.ack, occ); end
        tick();
        checks++; if (in_l.ack !== 1'b1 || occ !== 3'd3) begin errors++; $display("FAIL full_pop got ack=%b occ=%0d expected ack=1 occ=3", in_l.ack, occ); end
        checks++; if (out_l.packet !== pk(33)) begin errors++; $display("FAIL full_pop_pkt got %h expected %h", out_l.packet, pk(33)); end
        tick();
        in_l.req = 1'b0;
        checks++; if (occ !== 3'd3 || out_l.packet !== pk(34)) begin errors++; $display("FAIL full_pushpop got occ=%0d pkt=%h expected occ=3 pkt=%h", occ, out_l.packet, pk(34)); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_l.packet !== pk(34 + i)) begin errors++; $display("FAIL full_drain got %h expected %h", out_l.packet, pk(34 + i)); end
            tick();
        end
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL full_end_occ got %0d expected 0", occ); end
    endtask

    task automatic test_wrap();
        packet_t     exp_q [$];
        logic [31:0] req_pat;
        logic [31:0] ack_pat;
        int          pushed;
        int          popped;
        int          cyc;
        logic        do_push;
        logic        do_pop;
        req_pat = 32'hB76D_3E5B;
        ack_pat = 32'h6C9A_B3D6;
        pushed = 0; popped = 0; cyc = 0;
        while (popped < 11 && cyc < 80) begin
            in_l.req    = (pushed < 11) && (cyc >= 32 || req_pat[cyc % 32]);
            in_l.packet = pk(48 + pushed);
            out_l.ack   = (cyc >= 32) || ack_pat[cyc % 32];
            #1;
            checks++; if (int'(occ) !== exp_q.size()) begin errors++; $display("FAIL wrap_occ got %0d expected %0d", occ, exp_q.size()); end
            do_pop  = out_l.ack && (exp_q.size() > 0);
            do_push = in_l.req && (exp_q.size() < 4);
            if (do_pop) begin
                checks++; if (out_l.packet !== pk(48 + popped)) begin errors++; $display("FAIL wrap_order got %h expected %h", out_l.packet, pk(48 + popped)); end
                void'(exp_q.pop_front());
                popped++;
            end
            if (do_push) begin
                exp_q.push_back(pk(48 + pushed));
                pushed++;
            end
            tick();
            cyc++;
        end
        in_l.req = 1'b0; out_l.ack = 1'b0;
        checks++; if (popped != 11) begin errors++; $display("FAIL wrap_timeout got %0d pops expected 11", popped); end
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL wrap_end_occ got %0d expected 0", occ); end
    endtask

    task automatic test_mid_reset();
        out_l.ack = 1'b0; in_l.req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_l.packet = pk(64 + i);
            tick();
        end
        checks++; if (occ !== 3'd3) begin errors++; $display("FAIL mid_pre_occ got %0d expected 3", occ); end
        reset = 1'b1; in_l.packet = pk(70); out_l.ack = 1'b1;
        tick();
        reset = 1'b0; in_l.req = 1'b0; out_l.ack = 1'b0;
        checks++; if (out_l.req !== 1'b0 || out_l.packet !== `NULL_PACKET) begin errors++; $display("FAIL mid_rst_out got req=%b pkt=%h expected req=0 pkt=%h", out_l.req, out_l.packet, `NULL_PACKET); end
        checks++; if (in_l.ack !== 1'b1 || occ !== 3'd0) begin errors++; $display("FAIL mid_rst_state got ack=%b occ=%0d expected ack=1 occ=0", in_l.ack, occ); end
        in_l.req = 1'b1; in_l.packet = pk(80);
        tick();
        in_l.req = 1'b0;
        checks++; if (out_l.packet !== pk(80) || occ !== 3'd1) begin errors++; $display("FAIL mid_first got pkt=%h occ=%0d expected pkt=%h occ=1", out_l.packet, occ, pk(80)); end
        out_l.ack = 1'b1;
        tick();
        out_l.ack = 1'b0;
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL mid_end_occ got %0d expected 0", occ); end
    endtask

    task automatic test_stability();
        out_l.ack = 1'b0; in_l.req = 1'b1;
        in_l.packet = pk(96); tick();
        in_l.packet = pk(97); tick();
        in_l.req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (out_l.packet !== pk(96) || occ !== 3'd2) begin errors++; $display("FAIL stable got pkt=%h occ=%0d expected pkt=%h occ=2", out_l.packet, occ, pk(96)); end
        end
        out_l.ack = 1'b1;
        tick();
        checks++; if (out_l.packet !== pk(97)) begin errors++; $display("FAIL stable_next got %h expected %h", out_l.packet, pk(97)); end
        tick();
        out_l.ack = 1'b0;
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL stable_end_occ got %0d expected 0", occ); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_fill_drain();
        test_streaming();
        test_full_pop();
        test_wrap();
        test_mid_reset();
        test_stability();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/link_fifo_buffer.md
LINK_FIFO_BUFFER -- requirements
Module: link_fifo_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of packet entries; legal values are powers of two, 2 to 32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port input_link, link_if.receiver: upstream link (req, packet in; ack out), typically driven by a link combiner output.
REQ-005 SHALL have port output_link, link_if.sender: downstream link (req, packet out; ack in).
REQ-006 SHALL have port occupancy, output, $clog2(DEPTH)+1 bits: current number of stored packets.

Function
REQ-007 SHALL complete a transfer on a link only at a rising clk edge where that link's req and ack are both high.
REQ-008 SHALL drive input_link.ack = 1 exactly when occupancy < DEPTH, with no combinational dependence on input_link.req or output_link.ack.
REQ-009 SHALL drive output_link.req = 1 exactly when occupancy > 0.
REQ-010 SHALL drive output_link.packet with the oldest stored packet when occupancy > 0, else `NULL_PACKET.
REQ-011 SHALL deliver packets in strict arrival order, with no loss or duplication.
REQ-012 SHALL have a minimum latency of one cycle: a packet accepted at edge N is presented on output_link at the cycle following edge N.
REQ-013 SHALL, on push only, write the packet at the tail pointer, increment tail modulo DEPTH, and increment occupancy.
REQ-014 SHALL, on pop only, increment the head pointer modulo DEPTH and decrement occupancy.
REQ-015 SHALL, on simultaneous push and pop (possible only when 0 < occupancy < DEPTH), advance both pointers and leave occupancy unchanged.
REQ-016 SHALL, when empty, do a push only, since output_link.req is low; a bypass from input to output is not permitted.
REQ-017 SHALL, when full, do no push (ack low), and a pop in that cycle SHALL make ack high in the next cycle only.
REQ-018 SHALL wrap pointers from DEPTH-1 to 0 with no bubble; the pointer width is $clog2(DEPTH).
REQ-019 SHALL hold output_link.packet stable while output_link.req is high and output_link.ack is low.
REQ-020 SHALL tie every control output to a defined 0/1 value every cycle, with no X outputs after reset.

Reset
REQ-021 SHALL, while reset is high at an edge, clear head, tail, and occupancy to 0 regardless of link activity; packets in flight are discarded.
REQ-022 SHALL drive output_link.req=0, output_link.packet=`NULL_PACKET, input_link.ack=1, and occupancy=0 in the cycle after reset.
REQ-023 SHALL not require the storage array to be reset; its contents SHALL be unobservable when empty.

Structure
REQ-024 SHALL take packet_t, `NULL_PACKET, and link_if from the shared interconnect package/header; no new typedefs are added locally.
REQ-025 SHALL compute derived widths locally from DEPTH via $clog2; no new package constants are needed.
REQ-026 SHALL implement storage, pointers, and occupancy counter in this module; no sub-module is needed.

Verification
REQ-027 SHALL cover fill/drain: DEPTH=4, output ack=0, push A,B,C,D -> ack low after 4th, occupancy=4; then ack=1 -> A,B,C,D out on 4 consecutive cycles, occupancy returns to 0.
REQ-028 SHALL cover streaming: input req held high with 10 distinct packets, output ack=1 -> first out one cycle after first accept, then one per cycle, occupancy steady at 1, order preserved.
REQ-029 SHALL cover full with simultaneous pop: occupancy=4, input req=1, output ack=1 -> pop only; next cycle ack=1 and occupancy=3; following edge push+pop, occupancy stays 3.
REQ-030 SHALL cover wrap-around: 11 pushes and 11 pops interleaved in random occupancy patterns (DEPTH=4) -> output sequence equals input sequence exactly.
REQ-031 SHALL cover mid-operation reset: occupancy=3, assert reset one cycle -> next cycle output req=0, packet=`NULL_PACKET, ack=1, occupancy=0; a subsequent push E pops E first.
REQ-032 SHALL cover stability: output ack=0 for 5 cycles with occupancy=2 -> output_link.packet unchanged, no pointer movement.
